// File: rtl/cp0_pkg.sv
// cp0_pkg: CP0 register numbers, exception codes, Status/Cause field positions and reset value.
package cp0_pkg;
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_TR   = 5'd13;
  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int CA_TI  = 30;
  localparam int CA_BD  = 31;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  function automatic logic is_addr_exc(input logic [4:0] code);
    return code == EXC_ADEL || code == EXC_ADES;
  endfunction
endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count prescaler, Count/Compare registers and the sticky timer interrupt TI.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);
  localparam logic [1:0] P_LAST = 2'(COUNT_DIV - 1);
  logic [1:0] presc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      if (count_we) begin
        count <= wdata;
        presc <= '0;
      end else if (presc == P_LAST) begin
        presc <= '0;
        count <= count + 32'd1;
      end else presc <= presc + 2'd1;
      if (compare_we) begin
        compare <= wdata;
        ti      <= 1'b0;
      end else if (count == compare) ti <= 1'b1;
    end
  end
endmodule

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: CP0 registers, interrupt pending detection and exception/ERET redirect.
// Define CP0_TIMER_EN to include Count/Compare and the timer interrupt.
module cp0_ctrl
  import cp0_pkg::*;
#(
  parameter int          HW_INT_N   = 6,
  parameter logic [31:0] EXC_VECTOR = 32'hbfc0_0380,
  parameter int          COUNT_DIV  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we_i,
  input  logic [4:0]          waddr_i,
  input  logic [31:0]         wdata_i,
  input  logic [4:0]          raddr_i,
  output logic [31:0]         rdata_o,
  input  logic [HW_INT_N-1:0] hw_int_i,
  input  logic                exc_valid_i,
  input  logic [4:0]          exc_code_i,
  input  logic [31:0]         exc_pc_i,
  input  logic                exc_bd_i,
  input  logic [31:0]         exc_badvaddr_i,
  input  logic                eret_i,
  output logic                int_pending_o,
  output logic                redirect_o,
  output logic [31:0]         redirect_pc_o,
  output logic [31:0]         status_o,
  output logic [31:0]         cause_o,
  output logic [31:0]         epc_o
);
  if (HW_INT_N < 1 || HW_INT_N > 6 || COUNT_DIV < 1 || COUNT_DIV > 4) begin : g_bad_param
    $error("cp0_ctrl: HW_INT_N must be 1..6 and COUNT_DIV 1..4");
  end
  logic [7:0]  im;
  logic        exl, ie, bd;
  logic [1:0]  swip;
  logic [5:0]  hwip, hw_ext;
  logic [4:0]  code;
  logic [31:0] epc, bva, count, compare;
  logic        ti;
  logic [7:0]  ip;
  logic        st_we, ca_we, epc_we;
  assign st_we  = we_i && waddr_i == CP0_STATUS;
  assign ca_we  = we_i && waddr_i == CP0_CAUSE;
  assign epc_we = we_i && waddr_i == CP0_EPC;
`ifdef CP0_TIMER_EN
  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .count_we  (we_i && waddr_i == CP0_COUNT),
    .compare_we(we_i && waddr_i == CP0_COMPARE),
    .wdata     (wdata_i),
    .count     (count),
    .compare   (compare),
    .ti        (ti)
  );
`else
  assign count   = '0;
  assign compare = '0;
  assign ti      = 1'b0;
`endif
  always_comb begin
    hw_ext = '0;
    hw_ext[HW_INT_N-1:0] = hw_int_i;
  end
  assign ip = {hwip[5] | ti, hwip[4:0], swip};
  always_comb begin
    status_o = STATUS_RESET;
    status_o[15:8] = im;
    status_o[ST_EXL] = exl;
    status_o[ST_IE] = ie;
    cause_o = '0;
    cause_o[CA_BD] = bd;
    cause_o[CA_TI] = ti;
    cause_o[15:8] = ip;
    cause_o[6:2] = code;
  end
  assign epc_o         = epc;
  assign int_pending_o = |(ip & im) & ie & ~exl;
  assign redirect_o    = exc_valid_i | eret_i;
  assign redirect_pc_o = exc_valid_i ? EXC_VECTOR : epc;
  always_comb begin
    case (raddr_i)
      CP0_BADVADDR: rdata_o = bva;
      CP0_COUNT:    rdata_o = count;
      CP0_COMPARE:  rdata_o = compare;
      CP0_STATUS:   rdata_o = status_o;
      CP0_CAUSE:    rdata_o = cause_o;
      CP0_EPC:      rdata_o = epc;
      default:      rdata_o = '0;
    endcase
  end
  // Exception owns EXL/EPC/BD/ExcCode/BadVAddr; ERET beats an MTC0 to EXL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im   <= '0;
      exl  <= 1'b0;
      ie   <= 1'b0;
      swip <= '0;
      hwip <= '0;
      bd   <= 1'b0;
      code <= '0;
      epc  <= '0;
      bva  <= '0;
    end else begin
      hwip <= hw_ext;
      if (st_we) begin
        im <= wdata_i[15:8];
        ie <= wdata_i[ST_IE];
      end
      if (ca_we) swip <= wdata_i[9:8];
      exl <= exc_valid_i | (~eret_i & (st_we ? wdata_i[ST_EXL] : exl));
      if (exc_valid_i) begin
        code <= exc_code_i;
        if (!exl) begin
          epc <= exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
          bd  <= exc_bd_i;
        end
        if (is_addr_exc(exc_code_i)) bva <= exc_badvaddr_i;
      end else if (epc_we) epc <= wdata_i;
    end
  end
endmodule
